// File: rtl/cmd_rtn_pkg.sv
// Shared constants and state encoding for the command-return framer.
// Holds sync bytes, header size, default buffer depth and length width.
package cmd_rtn_pkg;

  localparam int CMD_MAX_LEN = 2048;
  localparam int LEN_W       = $clog2(CMD_MAX_LEN) + 1;
  localparam int HDR_LEN     = 4;

  localparam logic [7:0] SYNC_HI = 8'hEB;
  localparam logic [7:0] SYNC_LO = 8'h90;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SKIP = 3'd1;
  localparam logic [2:0] ST_CAPT = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_HDR  = 3'd4;
  localparam logic [2:0] ST_PAY  = 3'd5;
  localparam logic [2:0] ST_CSUM = 3'd6;
  localparam logic [2:0] ST_GAP  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_SKIP = ST_SKIP,
    S_CAPT = ST_CAPT,
    S_WAIT = ST_WAIT,
    S_HDR  = ST_HDR,
    S_PAY  = ST_PAY,
    S_CSUM = ST_CSUM,
    S_GAP  = ST_GAP
  } state_e;

endpackage

// File: rtl/cmd_rtn_buf_ram.sv
// Packet store: simple dual-port RAM, sync write, 1-cycle registered read.
// Ports: clk, we_i/waddr_i/wdata_i write side, raddr_i/rdata_o read side.
module cmd_rtn_buf_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/cmd_rtn_framer.sv
// Store-and-forward framer: acks one request, buffers the packet, then
// emits sync/length/payload/xor-checksum to the MAC, followed by a gap.
// Ports: clk, rst (async high); req_din/req_din_en in, req_ack out;
// mac_busy in; mac_dout/mac_dout_en, frame_cnt, trunc_flag out.
module cmd_rtn_framer
  import cmd_rtn_pkg::*;
#(
  parameter int ACK_LAT = 2,
  parameter int MAX_LEN = CMD_MAX_LEN,
  parameter int GAP_CYC = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  req_din,
  input  logic        req_din_en,
  output logic        req_ack,
  input  logic        mac_busy,
  output logic [7:0]  mac_dout,
  output logic        mac_dout_en,
  output logic [15:0] frame_cnt,
  output logic        trunc_flag
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;

  state_e      state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d;
  logic [7:0]  csum_q, csum_d;
  logic        trunc_q, trunc_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        ack_q, ack_d;
  logic [7:0]  dout_q, dout_d;
  logic        den_q, den_d;

  logic          ram_we;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;
  logic [15:0]   len_ext;

  assign len_ext = 16'(len_q);

  cmd_rtn_buf_ram #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (len_q[AW-1:0]),
    .wdata_i (req_din),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    csum_d    = csum_q;
    trunc_d   = trunc_q;
    fcnt_d    = fcnt_q;
    ack_d     = 1'b0;
    dout_d    = 8'h00;
    den_d     = 1'b0;
    ram_we    = 1'b0;
    ram_raddr = '0;

    unique case (state_q)
      S_IDLE: begin
        if (req_din_en) begin
          ack_d   = 1'b1;
          state_d = S_SKIP;
          cnt_d   = '0;
          len_d   = '0;
          csum_d  = 8'h00;
        end
      end

      // Ack-latency window; a dropped enable here is an empty packet.
      S_SKIP: begin
        if (!req_din_en) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LW'(ACK_LAT - 1)) begin
          state_d = S_CAPT;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end

      // Bytes past the buffer depth are consumed but dropped.
      S_CAPT: begin
        if (req_din_en) begin
          if (len_q < LW'(MAX_LEN)) begin
            ram_we = 1'b1;
            len_d  = len_q + LW'(1);
            csum_d = csum_q ^ req_din;
          end else begin
            trunc_d = 1'b1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!mac_busy) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end

      // Last header byte also launches the RAM read of payload byte 0.
      S_HDR: begin
        den_d = 1'b1;
        cnt_d = cnt_q + LW'(1);
        unique case (cnt_q[1:0])
          2'd0: dout_d = SYNC_HI;
          2'd1: dout_d = SYNC_LO;
          2'd2: begin
            dout_d = len_ext[15:8];
            csum_d = csum_q ^ len_ext[15:8];
          end
          default: begin
            dout_d = len_ext[7:0];
            csum_d = csum_q ^ len_ext[7:0];
          end
        endcase
        if (cnt_q == LW'(HDR_LEN - 1)) begin
          ram_raddr = '0;
          cnt_d     = '0;
          state_d   = (len_q == '0) ? S_CSUM : S_PAY;
        end
      end

      // Read one ahead so the next byte is ready each cycle.
      S_PAY: begin
        den_d     = 1'b1;
        dout_d    = ram_rdata;
        ram_raddr = cnt_q[AW-1:0] + AW'(1);
        if (cnt_q == len_q - LW'(1)) begin
          state_d = S_CSUM;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end

      S_CSUM: begin
        den_d   = 1'b1;
        dout_d  = csum_q;
        state_d = S_GAP;
        cnt_d   = '0;
        fcnt_d  = fcnt_q + 16'd1;
      end

      S_GAP: begin
        if (cnt_q == LW'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      csum_q  <= 8'h00;
      trunc_q <= 1'b0;
      fcnt_q  <= 16'd0;
      ack_q   <= 1'b0;
      dout_q  <= 8'h00;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      trunc_q <= trunc_d;
      fcnt_q  <= fcnt_d;
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      den_q   <= den_d;
    end
  end

  assign req_ack     = ack_q;
  assign mac_dout    = dout_q;
  assign mac_dout_en = den_q;
  assign frame_cnt   = fcnt_q;
  assign trunc_flag  = trunc_q;

endmodule

// File: tb/tb_cmd_rtn_framer.sv
// Randomized bench for cmd_rtn_framer with a transaction-level timeline
// model and a per-cycle output compare.
module tb_cmd_rtn_framer;

  localparam int N    = 16384;
  localparam int MAXL = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  req_din = 8'h00;
  logic        req_din_en = 1'b0;
  logic        req_ack;
  logic        mac_busy = 1'b0;
  logic [7:0]  mac_dout;
  logic        mac_dout_en;
  logic [15:0] frame_cnt;
  logic        trunc_flag;

  cmd_rtn_framer dut (
    .clk         (clk),
    .rst         (rst),
    .req_din     (req_din),
    .req_din_en  (req_din_en),
    .req_ack     (req_ack),
    .mac_busy    (mac_busy),
    .mac_dout    (mac_dout),
    .mac_dout_en (mac_dout_en),
    .frame_cnt   (frame_cnt),
    .trunc_flag  (trunc_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic        exp_ack   [N];
  logic        exp_en    [N];
  logic [7:0]  exp_dout  [N];
  logic [15:0] exp_fcnt  [N];
  logic        exp_trunc [N];

  int          idle_at = 0;
  int          req_r = -1;
  int          fcnt_m = 0;
  logic [7:0]  pkt [$];
  logic [7:0]  cap [$];

  int   ack_cyc = 0;
  int   sof_cyc = 0;
  int   low_run = 0;
  int   last_gap = 0;
  logic prev_en = 1'b0;

  // Per-cycle compare plus a passive monitor of the byte stream.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      checks++;
      if ({req_ack, mac_dout_en, mac_dout, frame_cnt, trunc_flag} !==
          {exp_ack[cyc], exp_en[cyc], exp_dout[cyc], exp_fcnt[cyc],
           exp_trunc[cyc]}) begin
        errors++;
        $display("FAIL out cyc=%0d got ack=%b en=%b dout=%h fcnt=%0d trunc=%b want ack=%b en=%b dout=%h fcnt=%0d trunc=%b",
                 cyc, req_ack, mac_dout_en, mac_dout, frame_cnt, trunc_flag,
                 exp_ack[cyc], exp_en[cyc], exp_dout[cyc], exp_fcnt[cyc],
                 exp_trunc[cyc]);
      end
    end
    if (req_ack) ack_cyc = cyc;
    if (mac_dout_en) begin
      cap.push_back(mac_dout);
      if (!prev_en) begin
        sof_cyc  = cyc;
        last_gap = low_run;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_en = mac_dout_en;
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input logic [7:0] v);
    if (k < N) begin
      exp_en[k]   = 1'b1;
      exp_dout[k] = v;
    end
  endtask

  task automatic set_fcnt(input int from, input logic [15:0] v);
    for (int k = from; k < N; k++) exp_fcnt[k] = v;
  endtask

  task automatic set_trunc(input int from, input logic v);
    for (int k = from; k < N; k++) exp_trunc[k] = v;
  endtask

  // Drives one packet held in pkt. Frame timing: wait sampled clear at m,
  // sync at m+2, len+5 bytes, count bumps on the checksum cycle, and the
  // block is idle again at m+18+len.
  task automatic send(input int wbusy, input bit abort, input bit early);
    int c, t, e, m, n, ln, k;
    logic [7:0] cs;
    logic [15:0] l16;
    if (req_r < 0) begin
      req_din_en = 1'b1;
      req_din    = 8'($urandom);
      req_r      = cyc;
    end
    c = (req_r > idle_at) ? req_r : idle_at;
    t = c + 1;
    if (t < N) exp_ack[t] = 1'b1;
    while (cyc < t) begin
      step();
      req_din  = 8'($urandom);
      mac_busy = 1'($urandom);
    end
    req_r = -1;
    if (abort) begin
      step();
      req_din_en = 1'b0;
      idle_at = t + 14;
      return;
    end
    n  = pkt.size();
    ln = (n > MAXL) ? MAXL : n;
    e  = t + 2 + n;
    m  = e + 1 + wbusy;
    if (n > MAXL) set_trunc(t + 3 + MAXL, 1'b1);
    cs = 8'h00;
    for (int i = 0; i < ln; i++) cs ^= pkt[i];
    l16 = 16'(ln);
    cs = cs ^ l16[15:8] ^ l16[7:0];
    k = m + 2;
    put(k, 8'hEB); put(k + 1, 8'h90);
    put(k + 2, l16[15:8]); put(k + 3, l16[7:0]);
    for (int i = 0; i < ln; i++) put(k + 4 + i, pkt[i]);
    put(k + 4 + ln, cs);
    fcnt_m++;
    set_fcnt(m + 6 + ln, 16'(fcnt_m));
    idle_at = m + 18 + ln;
    step();
    req_din = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      step();
      req_din  = pkt[i];
      mac_busy = 1'($urandom);
    end
    step();
    req_din_en = 1'b0;
    mac_busy   = 1'($urandom);
    for (int i = 0; i < wbusy; i++) begin
      step();
      mac_busy = 1'b1;
      if (early && i == 0) begin
        req_din_en = 1'b1;
        req_r      = cyc;
      end
    end
    step();
    mac_busy = 1'b0;
    repeat (3) begin
      step();
      mac_busy = 1'($urandom);
      req_din  = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    while (cyc < idle_at) begin
      step();
      mac_busy = 1'($urandom);
      req_din  = 8'($urandom);
    end
  endtask

  task automatic one(input logic [7:0] b);
    pkt.delete();
    pkt.push_back(b);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1 [8];
    logic [7:0] t7 [6];
    int n, f0;
    t1 = '{8'hEB, 8'h90, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
    t7 = '{8'hEB, 8'h90, 8'h00, 8'h01, 8'hAA, 8'hAB};
    for (int k = 0; k < N; k++) begin
      exp_ack[k] = 0; exp_en[k] = 0; exp_dout[k] = 0;
      exp_fcnt[k] = 0; exp_trunc[k] = 0;
    end

    repeat (3) step();
    chk("rst_ack", int'(req_ack), 0);
    chk("rst_en", int'(mac_dout_en), 0);
    chk("rst_dout", int'(mac_dout), 0);
    chk("rst_fcnt", int'(frame_cnt), 0);
    chk("rst_trunc", int'(trunc_flag), 0);
    rst = 1'b0;
    idle_at = cyc;

    // 01 02 03 with the MAC free
    cap.delete();
    pkt = '{8'h01, 8'h02, 8'h03};
    send(0, 0, 0);
    wait_idle();
    chk("t1_size", cap.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < cap.size())
        chk($sformatf("t1_b%0d", i), int'(cap[i]), int'(t1[i]));
    chk("t1_fcnt", int'(frame_cnt), 1);

    // enable dropped inside the ack window
    cap.delete();
    send(0, 1, 0);
    wait_idle();
    chk("abort_bytes", cap.size(), 0);
    chk("abort_fcnt", int'(frame_cnt), 1);

    // random packets, some back-to-back
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 40);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      send($urandom_range(0, 4), 0, 0);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    // long MAC stall with a second request pending
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(50, 0, 1);
    chk("busy_sof", sof_cyc - ack_cyc, 60);
    one(8'h5A);
    send(0, 0, 0);
    wait_idle();

    // overflow: 2050 incrementing bytes
    pkt.delete();
    for (int i = 0; i < 2050; i++) pkt.push_back(8'(i));
    cap.delete();
    send(0, 0, 0);
    wait_idle();
    chk("tr_size", cap.size(), 2053);
    if (cap.size() == 2053) begin
      chk("tr_lenhi", int'(cap[2]), 8'h08);
      chk("tr_lenlo", int'(cap[3]), 8'h00);
      chk("tr_p0", int'(cap[4]), 8'h00);
      chk("tr_p996", int'(cap[1000]), 8'hE4);
      chk("tr_plast", int'(cap[2051]), 8'hFF);
      chk("tr_csum", int'(cap[2052]), 8'h08);
    end
    chk("tr_flag", int'(trunc_flag), 1);

    // back-to-back 1-byte packets
    f0 = int'(frame_cnt);
    one(8'h3C);
    send(0, 0, 0);
    one(8'hC3);
    send(0, 0, 0);
    wait_idle();
    chk("b2b_gap", last_gap, 18);
    chk("b2b_fcnt", int'(frame_cnt), f0 + 2);

    // reset in the middle of a payload
    pkt.delete();
    for (int i = 0; i < 100; i++) pkt.push_back(8'($urandom));
    send(0, 0, 0);
    repeat (7) step();
    rst = 1'b1;
    for (int k = cyc; k < N; k++) begin
      exp_ack[k] = 0; exp_en[k] = 0; exp_dout[k] = 0;
      exp_fcnt[k] = 0; exp_trunc[k] = 0;
    end
    fcnt_m = 0;
    #1;
    chk("mid_rst_en", int'(mac_dout_en), 0);
    chk("mid_rst_fcnt", int'(frame_cnt), 0);
    chk("mid_rst_trunc", int'(trunc_flag), 0);
    step();
    step();
    rst = 1'b0;
    idle_at = cyc;
    cap.delete();
    one(8'hAA);
    send(0, 0, 0);
    wait_idle();
    chk("aa_size", cap.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < cap.size())
        chk($sformatf("aa_b%0d", i), int'(cap[i]), int'(t7[i]));
    chk("aa_fcnt", int'(frame_cnt), 1);

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
